// File: rtl/memory_flash_prefetch.sv
// memory_flash_prefetch: credit-limited flash word prefetcher that streams each 32-bit word out as two halfwords, upper first.
module memory_flash_prefetch #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [18:0] i_start_address,
  input  logic [8:0]  i_length,
  input  logic        i_cancel,
  output logic        o_active,
  output logic        o_request,
  output logic [18:0] o_address,
  input  logic        i_busy,
  input  logic        i_ack,
  input  logic [31:0] i_data,
  output logic        o_rd_valid,
  input  logic        i_rd_ready,
  output logic [15:0] o_rd_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;
  state_t        state;
  logic [18:0]   addr;
  logic [8:0]    rem;
  logic [4:0]    outst, outst_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] wp, rp;
  logic          half, half_nxt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic          live, accept, push, pop, hs;
  assign live       = state == FETCH || state == DRAIN;
  assign o_active   = state != IDLE;
  // outstanding + occupancy only shrinks while a request waits, so this stays high until accepted
  assign o_request  = state == FETCH && rem != 9'd0 && (6'(outst) + 6'(cnt) < 6'(FIFO_DEPTH)) && !i_cancel;
  assign accept     = o_request && !i_busy;
  assign o_address  = addr;
  assign o_rd_valid = cnt != '0;
  assign o_rd_data  = !o_rd_valid ? 16'h0 : half ? mem[rp][15:0] : mem[rp][31:16];
  assign hs         = o_rd_valid && i_rd_ready;
  assign pop        = hs && half;
  assign push       = i_ack && live && !i_cancel;
  always_comb begin
    outst_nxt = outst + 5'(accept) - 5'(i_ack && outst != '0);
    cnt_nxt   = cnt + CW'(push) - CW'(pop);
    half_nxt  = hs ? !half : half;
  end
  always_ff @(posedge i_clk)
    if (push) mem[wp] <= i_data;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      addr  <= '0;
      rem   <= '0;
      outst <= '0;
      cnt   <= '0;
      wp    <= '0;
      rp    <= '0;
      half  <= 1'b0;
    end else begin
      outst <= outst_nxt;
      case (state)
        IDLE: if (i_start && !i_cancel) begin
          state <= FETCH;
          addr  <= i_start_address;
          rem   <= i_length == 9'd0 ? 9'd256 : i_length;
        end
        FLUSH: if (outst_nxt == '0) state <= IDLE;
        default: if (i_cancel) begin
          state <= FLUSH;
          cnt   <= '0;
          wp    <= '0;
          rp    <= '0;
          half  <= 1'b0;
        end else begin
          if (accept) begin
            addr <= addr + 19'd1;
            rem  <= rem - 9'd1;
          end
          if (push) wp <= wp + AW'(1);
          if (pop) rp <= rp + AW'(1);
          cnt  <= cnt_nxt;
          half <= half_nxt;
          if (state == FETCH && accept && rem == 9'd1) state <= DRAIN;
          else if (state == DRAIN && outst_nxt == '0 && cnt_nxt == '0 && !half_nxt) state <= IDLE;
        end
      endcase
    end
  ack_into_full_fifo: assert property (@(posedge i_clk) disable iff (i_reset) !(push && cnt == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_memory_flash_prefetch.sv
// tb_memory_flash_prefetch: directed scenarios with address and halfword scoreboards checked by a negedge monitor.
module tb_memory_flash_prefetch;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [18:0] i_start_address = '0;
  logic [8:0]  i_length = '0;
  logic        i_cancel = 1'b0;
  logic        o_active, o_request, o_rd_valid;
  logic [18:0] o_address;
  logic        i_busy = 1'b0;
  logic        i_ack = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_rd_ready = 1'b0;
  logic [15:0] o_rd_data;

  memory_flash_prefetch #(.FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_start_address(i_start_address),
    .i_length(i_length), .i_cancel(i_cancel), .o_active(o_active), .o_request(o_request),
    .o_address(o_address), .i_busy(i_busy), .i_ack(i_ack), .i_data(i_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data)
  );

  always #5 i_clk = ~i_clk;

  int pass_n = 0, total_n = 0;
  int acc_n = 0, hs_n = 0, ack_n = 0, cyc = 0, lat = 2;
  logic [18:0] exp_addr[$];
  logic [15:0] exp_hw[$];
  int          due_q[$];
  logic [18:0] pend_q[$];
  logic        acc_s = 1'b0;
  logic [18:0] acc_a = '0;

  function automatic logic [31:0] fw(input logic [18:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0] + 16'h0101};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic expect_xfer(input logic [18:0] a, input int n);
    logic [18:0] wa;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      wa = a + 19'(i);
      d = fw(wa);
      exp_addr.push_back(wa);
      exp_hw.push_back(d[31:16]);
      exp_hw.push_back(d[15:0]);
    end
  endtask

  task automatic start(input logic [18:0] a, input logic [8:0] n);
    i_start = 1'b1;
    i_start_address = a;
    i_length = n;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    for (int i = 0; i < max; i++) begin
      if (!o_active) break;
      @(posedge i_clk); #1;
    end
    chk(name, 32'(o_active), 32'd0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
    end
  endtask

  // monitor: compares every accepted address and every consumed halfword against the queues
  always @(negedge i_clk) begin
    acc_s = !i_reset && o_request && !i_busy;
    acc_a = o_address;
    if (acc_s) begin
      acc_n++;
      if (exp_addr.size() == 0) chk("unexpected_request", 32'(o_address), 32'h7FFFFFFF);
      else chk("address", 32'(o_address), 32'(exp_addr.pop_front()));
    end
    if (!i_reset && o_rd_valid && i_rd_ready) begin
      hs_n++;
      if (exp_hw.size() == 0) chk("unexpected_halfword", 32'(o_rd_data), 32'hFFFFFFFF);
      else chk("halfword", 32'(o_rd_data), 32'(exp_hw.pop_front()));
    end
  end

  // flash model: acks each accepted request lat cycles later with fw(address)
  always @(posedge i_clk) begin
    #1;
    cyc++;
    i_ack = 1'b0;
    if (due_q.size() != 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      i_data = fw(pend_q.pop_front());
      i_ack = 1'b1;
      ack_n++;
    end
    if (acc_s) begin
      due_q.push_back(cyc + lat - 1);
      pend_q.push_back(acc_a);
    end
  end

  initial begin
    int base, abase, hbase;
    logic seen;
    #12;
    chk("rst_active", 32'(o_active), 0);
    chk("rst_request", 32'(o_request), 0);
    chk("rst_address", 32'(o_address), 0);
    chk("rst_rd_valid", 32'(o_rd_valid), 0);
    chk("rst_rd_data", 32'(o_rd_data), 0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    cycles(2);

    // start together with cancel in IDLE is ignored
    i_cancel = 1'b1;
    start(19'h00123, 9'd2);
    i_cancel = 1'b0;
    chk("start_cancel_idle", 32'(o_active), 0);

    // basic two-word transfer
    i_rd_ready = 1'b1;
    hbase = hs_n;
    expect_xfer(19'h00010, 2);
    start(19'h00010, 9'd2);
    chk("active_after_start", 32'(o_active), 1);
    wait_idle(40, "basic_idle");
    chk("basic_handshakes", 32'(hs_n - hbase), 4);
    chk("basic_drained", 32'(exp_hw.size()), 0);

    // address wraps at the top of flash
    expect_xfer(19'h7FFFF, 2);
    start(19'h7FFFF, 9'd2);
    wait_idle(40, "wrap_idle");
    chk("wrap_addr_drained", 32'(exp_addr.size()), 0);

    // request and address hold under busy
    base = acc_n;
    i_busy = 1'b1;
    expect_xfer(19'h00100, 1);
    start(19'h00100, 9'd1);
    for (int i = 0; i < 5; i++) begin
      chk("busy_request", 32'(o_request), 1);
      chk("busy_address", 32'(o_address), 32'h100);
      @(posedge i_clk); #1;
    end
    i_busy = 1'b0;
    wait_idle(40, "busy_idle");
    chk("busy_single_accept", 32'(acc_n - base), 1);

    // length 0 = 256 words; credit stalls at FIFO depth while consumer is blocked
    i_rd_ready = 1'b0;
    base = acc_n;
    hbase = hs_n;
    expect_xfer(19'h00000, 256);
    start(19'h00000, 9'd0);
    cycles(20);
    chk("credit_accepts", 32'(acc_n - base), 4);
    chk("credit_request_low", 32'(o_request), 0);
    chk("credit_rd_valid", 32'(o_rd_valid), 1);
    i_rd_ready = 1'b1;
    wait_idle(3000, "long_idle");
    chk("long_accepts", 32'(acc_n - base), 256);
    chk("long_handshakes", 32'(hs_n - hbase), 512);
    chk("long_drained", 32'(exp_hw.size()), 0);

    // cancel with 3 outstanding, then flush acks; start in FLUSH ignored
    lat = 10;
    abase = ack_n;
    expect_xfer(19'h00400, 8);
    exp_hw.delete();
    base = acc_n;
    start(19'h00400, 9'd8);
    for (int i = 0; i < 20 && acc_n - base < 3; i++) begin
      @(posedge i_clk); #1;
    end
    chk("cancel_outstanding", 32'(acc_n - base), 3);
    chk("pre_cancel_request", 32'(o_request), 1);
    i_cancel = 1'b1;
    #1;
    chk("cancel_request_drop", 32'(o_request), 0);
    @(posedge i_clk); #1;
    i_cancel = 1'b0;
    chk("cancel_rd_valid", 32'(o_rd_valid), 0);
    chk("flush_active", 32'(o_active), 1);
    start(19'h00200, 9'd2);
    wait_idle(40, "flush_idle");
    chk("flush_acks", 32'(ack_n - abase), 3);
    cycles(5);
    chk("flush_start_ignored", 32'(acc_n - base), 3);
    exp_addr.delete();

    // asynchronous reset mid-transfer; late acks ignored afterwards
    lat = 2;
    i_rd_ready = 1'b0;
    base = acc_n;
    expect_xfer(19'h00500, 8);
    exp_hw.delete();
    start(19'h00500, 9'd8);
    for (int i = 0; i < 20 && acc_n - base < 2; i++) begin
      @(posedge i_clk); #1;
    end
    #2;
    i_reset = 1'b1;
    #1;
    chk("async_active", 32'(o_active), 0);
    chk("async_request", 32'(o_request), 0);
    chk("async_address", 32'(o_address), 0);
    chk("async_rd_valid", 32'(o_rd_valid), 0);
    chk("async_rd_data", 32'(o_rd_data), 0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    exp_addr.delete();
    i_rd_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= o_rd_valid | o_active;
      @(posedge i_clk); #1;
    end
    chk("late_ack_ignored", 32'(seen), 0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/memory_flash_prefetch.md
MEMORY_FLASH_PREFETCH -- requirements
Module: memory_flash_prefetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, word capacity of read buffer; power of two, 2..16.
REQ-002 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_start  input  1  one-cycle pulse; begins a transfer; ignored unless state IDLE.
REQ-005 i_start_address  input  19  first flash word address; sampled with i_start.
REQ-006 i_length  input  9  word count; sampled with i_start; 0 means 256.
REQ-007 i_cancel  input  1  level; aborts the current transfer.
REQ-008 o_active  output  1  high while state is not IDLE.
REQ-009 o_request  output  1  flash read request.
REQ-010 o_address  output  19  flash word address, valid while o_request high.
REQ-011 i_busy  input  1  flash wait; request accepted on a cycle with o_request high and i_busy low.
REQ-012 i_ack  input  1  one-cycle read-data-valid from flash.
REQ-013 i_data  input  32  flash read word, valid with i_ack.
REQ-014 o_rd_valid  output  1  halfword available to consumer.
REQ-015 i_rd_ready  input  1  consumer accepts halfword when high with o_rd_valid.
REQ-016 o_rd_data  output  16  output halfword, bits [31:16] of a word first, then [15:0].

Function
REQ-017 States: IDLE, FETCH, DRAIN, FLUSH; IDLE -> FETCH on i_start.
REQ-018 In FETCH, o_request high only when issued_outstanding + FIFO occupancy < FIFO_DEPTH and remaining issue count > 0.
REQ-019 Once raised, o_request and o_address hold stable until accepted; no de-assertion while i_busy high, except by reset or i_cancel.
REQ-020 On acceptance: o_address increments by 1 (wraps 7FFFF -> 00000), remaining issue count decrements, outstanding count increments.
REQ-021 At most one acceptance per cycle; a new request may be presented the cycle after acceptance (back-to-back).
REQ-022 On i_ack: i_data written to FIFO, outstanding count decrements; simultaneous accept and ack leaves outstanding unchanged.
REQ-023 Credit rule guarantees no FIFO overflow; ack arriving with FIFO full is a design error, flagged in simulation only.
REQ-024 FETCH -> DRAIN when the last request is accepted.
REQ-025 DRAIN -> IDLE when outstanding = 0, FIFO empty, and half-select at upper half.
REQ-026 Output: o_rd_valid high whenever FIFO non-empty; o_rd_data from FIFO head per half-select; upper half first.
REQ-027 Handshake on upper half toggles half-select to lower; handshake on lower pops FIFO and returns half-select to upper.
REQ-028 Simultaneous FIFO push and pop SHALL be supported; occupancy unchanged.
REQ-029 o_rd_data stable while o_rd_valid high and i_rd_ready low.
REQ-030 First halfword available no earlier than the cycle after the first i_ack (FIFO registered).
REQ-031 i_cancel in FETCH or DRAIN: o_request drops same cycle (combinational), FIFO and half-select cleared next edge, o_rd_valid low from next cycle, state -> FLUSH.
REQ-032 FLUSH: acks counted down and data discarded; -> IDLE when outstanding = 0; i_start ignored in FLUSH.
REQ-033 i_cancel in IDLE has no effect; i_start with i_cancel in IDLE is ignored.
REQ-034 Counters sized for 256 words and FIFO_DEPTH outstanding without overflow.

Reset
REQ-035 On i_reset: state IDLE, o_active 0, o_request 0, o_address 0, o_rd_valid 0, o_rd_data 0, counters 0, FIFO empty, half-select upper.
REQ-036 Reset mid-transfer abandons all state; late acks after reset release are ignored while IDLE.

Verification
REQ-037 Start address 00010, length 2, flash ack 2 cycles after accept, i_rd_ready high -> halfwords in order [31:16],[15:0] of words 00010, 00011; o_active falls after 4th handshake.
REQ-038 Length 0, i_rd_ready low, i_busy 0 -> exactly FIFO_DEPTH requests issued then o_request low; releasing ready resumes; 256 words / 512 halfwords total.
REQ-039 Start address 7FFFF, length 2 -> o_address sequence 7FFFF, 00000.
REQ-040 i_busy held high 5 cycles on first request -> o_request and o_address stable all 5 cycles; single acceptance.
REQ-041 i_cancel with 3 outstanding -> o_request low immediately, o_rd_valid low next cycle, 3 acks discarded, IDLE after 3rd ack; i_start during FLUSH ignored.
REQ-042 i_reset asserted during FETCH -> all outputs at reset values asynchronously before next clock edge.
